// File: rtl/aes_pkg.sv
// Shared types and constants for the AES stream controller slice.
package aes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StUnload
  } aes_state_e;

  typedef logic [0:127] aes_block_t;
  typedef logic [0:31]  aes_word_t;

  localparam int unsigned WordBits  = 32;
  localparam logic [1:0]  FirstWord = 2'd0;
  localparam logic [1:0]  LastWord  = 2'd3;

  // Word 0 occupies bits [0:31], i.e. it is the most significant word.
  function automatic aes_word_t get_word(aes_block_t blk, logic [1:0] idx);
    return blk[{idx, 5'd0} +: WordBits];
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Word stream, AES core and status signals of aes_stream_ctrl.
interface aes_stream_ctrl_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_word_t  in_data;
  logic       in_is_key;
  logic       in_decrypt;
  aes_block_t message;
  aes_block_t key;
  logic       sel_cypher;
  logic       start;
  aes_block_t core_result;
  logic       core_done;
  logic       out_valid;
  logic       out_ready;
  aes_word_t  out_data;
  logic [1:0] err;

  modport master (
    output in_valid, in_data, in_is_key, in_decrypt, core_result, core_done, out_ready,
    input  in_ready, message, key, sel_cypher, start, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, in_is_key, in_decrypt, core_result, core_done, out_ready,
    output in_ready, message, key, sel_cypher, start, out_valid, out_data, err
  );

endinterface

// File: rtl/aes_word_unpacker.sv
// Holds a 128-bit result block and streams it out as four 32-bit words, MSW first.
module aes_word_unpacker
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  aes_block_t load_data,
  input  logic       active,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_word_t  out_data,
  output logic       last
);

  aes_block_t data_q;
  logic [1:0] idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      idx_q  <= FirstWord;
    end else if (load) begin
      data_q <= load_data;
      idx_q  <= FirstWord;
    end else if (active && out_ready) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

  // out_data only moves on a handshake, so it is stable under backpressure.
  assign out_valid = active;
  assign out_data  = get_word(data_q, idx_q);
  assign last      = active && out_ready && (idx_q == LastWord);

endmodule

// File: rtl/aes_stream_ctrl.sv
// Packs 32-bit key/message groups for an AES core and unpacks its result.
// Optional build macro AES_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYCLES.
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              reset,
  aes_stream_ctrl_if.slave bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  aes_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       is_key_q, is_key_d;
  logic       decrypt_q, decrypt_d;
  logic       key_loaded_q, key_loaded_d;
  aes_block_t grp_q, grp_d;
  aes_block_t key_q, key_d;
  aes_block_t msg_q, msg_d;
  logic       sel_q, sel_d;
  logic       err0_q, err0_d;

  logic       accept;
  logic       unpack_load;
  logic       unpack_last;
  aes_block_t grp_full;

  assign bus.in_ready   = (state_q == StIdle) || (state_q == StLoad);
  assign accept         = bus.in_valid && bus.in_ready;
  assign grp_full       = {grp_q[0:95], bus.in_data};
  assign bus.message    = msg_q;
  assign bus.key        = key_q;
  assign bus.sel_cypher = sel_q;
  assign bus.start      = (state_q == StStart);
  assign unpack_load    = (state_q == StWait) && bus.core_done;

`ifdef AES_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err1_q, err1_d;
  assign bus.err = {err1_q, err0_q};
`else
  assign bus.err = {1'b0, err0_q};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_key_d     = is_key_q;
    decrypt_d    = decrypt_q;
    key_loaded_d = key_loaded_q;
    grp_d        = grp_q;
    key_d        = key_q;
    msg_d        = msg_q;
    sel_d        = sel_q;
    err0_d       = err0_q;
`ifdef AES_TIMEOUT_EN
    tmo_d        = tmo_q;
    err1_d       = err1_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          is_key_d            = bus.in_is_key;
          decrypt_d           = bus.in_decrypt;
          grp_d[0:WordBits-1] = bus.in_data;
          cnt_d               = 2'd1;
          state_d             = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          grp_d[{cnt_q, 5'd0} +: WordBits] = bus.in_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastWord) begin
            cnt_d   = 2'd0;
            state_d = StIdle;
            if (is_key_q) begin
              key_d        = grp_full;
              key_loaded_d = 1'b1;
            end else if (key_loaded_q) begin
              msg_d   = grp_full;
              sel_d   = decrypt_q;
              state_d = StStart;
            end else begin
              err0_d = 1'b1;
            end
          end
        end
      end
      StStart: begin
        state_d = StWait;
`ifdef AES_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      StWait: begin
        if (bus.core_done) begin
          state_d = StUnload;
`ifdef AES_TIMEOUT_EN
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          err1_d  = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
`endif
        end
      end
      StUnload: begin
        if (unpack_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      is_key_q     <= 1'b0;
      decrypt_q    <= 1'b0;
      key_loaded_q <= 1'b0;
      grp_q        <= '0;
      key_q        <= '0;
      msg_q        <= '0;
      sel_q        <= 1'b0;
      err0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_key_q     <= is_key_d;
      decrypt_q    <= decrypt_d;
      key_loaded_q <= key_loaded_d;
      grp_q        <= grp_d;
      key_q        <= key_d;
      msg_q        <= msg_d;
      sel_q        <= sel_d;
      err0_q       <= err0_d;
    end
  end

`ifdef AES_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q  <= '0;
      err1_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      err1_q <= err1_d;
    end
  end
`endif

  aes_word_unpacker u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .load      (unpack_load),
    .load_data (bus.core_result),
    .active    (state_q == StUnload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .last      (unpack_last)
  );

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT-state cycles before timeout (used only with AES_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  input word valid.
REQ-005 in_ready  out  1  input word accepted when in_valid && in_ready.
REQ-006 in_data  in  [0:31]  input word.
REQ-007 in_is_key  in  1  sampled with the first word of a group; 1 = key group, 0 = message group.
REQ-008 in_decrypt  in  1  sampled with the first word of a message group; 1 = decrypt.
REQ-009 message  out  [0:127]  packed message to the AES core.
REQ-010 key  out  [0:127]  packed key to the AES core.
REQ-011 sel_cypher  out  1  encrypt/decrypt select to the core.
REQ-012 start  out  1  one-cycle core start pulse.
REQ-013 core_result  in  [0:127]  core output block.
REQ-014 core_done  in  1  core result valid, one-cycle pulse.
REQ-015 out_valid  out  1  output word valid.
REQ-016 out_ready  in  1  output word consumed when out_valid && out_ready.
REQ-017 out_data  out  [0:31]  output word.
REQ-018 err  out  [1:0]  sticky errors: bit0 = no key loaded, bit1 = timeout.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, START, WAIT and UNLOAD.
REQ-020 in_ready SHALL be 1 only in IDLE and LOAD.
REQ-021 Group word k (k = 0..3) SHALL be written to bits [32k : 32k+31]; word 0 is MSW.
REQ-022 IDLE, word accepted: latch in_is_key and in_decrypt, store word 0, counter = 1, go to LOAD.
REQ-023 LOAD: each accepted word SHALL advance the counter; on the 4th word of a key group, update key, set key_loaded, go to IDLE.
REQ-024 4th word of a message group with key_loaded = 1: go to START; with key_loaded = 0: set err[0], discard the group, go to IDLE.
REQ-025 START: start = 1 for exactly one cycle, then go to WAIT; start SHALL be asserted the cycle after the 4th message word is accepted.
REQ-026 message, key and sel_cypher SHALL be held stable from START until leaving WAIT.
REQ-027 core_done SHALL be sampled only in WAIT; on core_done, capture core_result into the output buffer, set counter = 0, go to UNLOAD.
REQ-028 UNLOAD: out_valid = 1, out_data = buffer word[counter]; each handshake SHALL advance the counter; after the 4th, go to IDLE.
REQ-029 out_data SHALL remain stable while out_valid && !out_ready.
REQ-030 The key SHALL persist across message groups until overwritten by a new key group or cleared by reset.
REQ-031 err bits SHALL be sticky until reset.

Reset
REQ-032 On reset: state = IDLE; counters = 0; key_loaded = 0; message, key, buffer = 0; sel_cypher, start, out_valid, err = 0.
REQ-033 Reset mid-operation (any state) SHALL abandon the transaction with no output emitted.

Configuration
REQ-034 With AES_TIMEOUT_EN defined: WAIT SHALL count cycles; reaching TIMEOUT_CYCLES without core_done SHALL set err[1] and return to IDLE with no output; a late core_done SHALL be ignored.
REQ-035 Without AES_TIMEOUT_EN: WAIT SHALL be unbounded; err[1] SHALL be tied to 0; no counter logic.

Structure
REQ-036 Shared package aes_pkg SHALL hold the FSM state enum, the 128-bit block typedef, and word-index constants.
REQ-037 Sub-module aes_word_unpacker (128-bit buffer to 32-bit valid/ready stream) SHALL implement UNLOAD.

Verification
REQ-038 Key group 00010203,04050607,08090a0b,0c0d0e0f, then message group 00112233,44556677,8899aabb,ccddeeff with in_decrypt = 0; core model returns 69c4e0d8_6a7b0430_d8cdb780_70b4c55a -> one start pulse, key/message packed MSW-first, output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
REQ-039 Message group sent after reset without a key -> err = 01, no start, in_ready = 1 the following cycle.
REQ-040 out_ready held low 5 cycles during UNLOAD -> out_data stays 69c4e0d8; remaining words delivered in order once released.
REQ-041 Reset asserted in WAIT -> all outputs 0; a following message group sets err[0].
REQ-042 With AES_TIMEOUT_EN and TIMEOUT_CYCLES = 8, core_done never asserted -> err = 10 after 8 WAIT cycles, return to IDLE, no out_valid.
REQ-043 Two message groups back-to-back with in_decrypt = 1 and a single key -> two start pulses, sel_cypher = 1, eight output words in order.
